mm_dot_core: RTL and testbench
==============================

Name: mm_dot_core

Overview:
- Parametrised, hard-sequenced successor to the single accumulator core in the N-core rectangular matrix multiplier.
- Computes C = A(P×Q) · B(Q×R). The core owns rows i = CORE_ID, CORE_ID+NUM_CORES, …
- Fetches A and B elements over a shared, arbitrated DRAM port, accumulates each dot product at full width, and writes C elements back.
- Replaces the microcoded instruction stream for the multiply kernel. NUM_CORES instances share one DRAM through an external arbiter.

Parameters:
- DATA_W, 16, element width of A, B and C.
- ADDR_W, 16, DRAM address width.
- DIM_W, 8, width of dimension inputs.
- NUM_CORES, 4, row stride between cores.
- A_BASE, 0, DRAM base address of A (row-major).
- B_BASE, 0, DRAM base address of B (row-major).
- C_BASE, 0, DRAM base address of C (row-major).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle start pulse, sampled in IDLE only.
- core_id  in  $clog2(NUM_CORES)  index of this core, stable while busy.
- dim_p  in  DIM_W  P, rows of A; sampled at start.
- dim_q  in  DIM_W  Q, inner dimension; sampled at start.
- dim_r  in  DIM_W  R, columns of B; sampled at start.
- dram_req  out  1  access request.
- dram_wr_en  out  1  write qualifier for dram_req.
- dram_gnt  in  1  grant; access completes in a cycle where dram_req and dram_gnt are both 1.
- dram_addr  out  ADDR_W  access address.
- dram_wdata  out  DATA_W  write data.
- dram_rdata  in  DATA_W  read data, valid the cycle after a granted read.
- busy  out  1  high from start acceptance until end_process.
- end_process  out  1  one-cycle pulse when this core's rows are finished.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, accumulator and indices cleared. Reset asserted mid-operation aborts immediately; no further DRAM access is made.
- States: IDLE, ELEM_INIT, RD_A, WAIT_A, RD_B, WAIT_B, WR_C, NEXT, FIN.
- IDLE:
  - On start, latch the dimensions and set i=core_id, j=0, busy=1.
  - If P=0, Q=0, R=0 or core_id≥P, go to FIN. Otherwise go to ELEM_INIT.
  - start while busy is ignored.
- ELEM_INIT: clear accumulator, k=0. Set a_ptr=A_BASE+i·Q, b_ptr=B_BASE+j.
- RD_A: dram_req=1, dram_wr_en=0, dram_addr=a_ptr. Hold until granted, then go to WAIT_A.
- WAIT_A: capture a_reg=dram_rdata, go to RD_B.
- RD_B: same as RD_A with dram_addr=b_ptr.
- WAIT_B:
  - acc += a_reg·dram_rdata, with unsigned operands.
  - a_ptr+=1, b_ptr+=R, k+=1.
  - If k==Q go to WR_C, else go to RD_A.
- WR_C: dram_req=1, dram_wr_en=1, dram_addr=C_BASE+i·R+j, dram_wdata=stored value. Hold until granted, then go to NEXT.
- NEXT:
  - j+=1.
  - If j==R: j=0, i+=NUM_CORES. If i≥P go to FIN, else go to ELEM_INIT.
  - Otherwise go to ELEM_INIT.
- FIN: end_process=1 for one cycle, busy=0, return to IDLE.
- Request hold rule: while waiting for grant, dram_req, dram_addr, dram_wr_en and dram_wdata are held stable. dram_req is 0 in every other state.
- Arithmetic:
  - Accumulator ACC_W = 2·DATA_W+DIM_W, so it never overflows.
  - Address arithmetic is modulo 2^ADDR_W; the wrap is silent.
  - Row index i is DIM_W+1 bits so the stride never wraps.
- Stored value: acc[DATA_W-1:0], i.e. truncation.
- Timing with dram_gnt tied 1:
  - Each C element takes 4·Q+3 cycles (ELEM_INIT, 4 per k, WR_C, NEXT).
  - First dram_req is 2 cycles after the start edge.

Optional Feature:
- SATURATE_EN defined: the stored value is min(acc, 2^DATA_W−1).
  - A sticky ovf output (1 bit) goes high on any clamped write. It is cleared by start or reset.
- SATURATE_EN undefined: truncation as above, and no ovf port.

Decomposition:
- Package mm_core_pkg holds:
  - FSM state enum typedef.
  - ACC_W derivation function.
  - The three base-address defaults.
- One natural sub-module: mm_mac, the registered multiply-accumulate with clear and enable, optional saturation, ACC_W output.

Test Plan:
- NUM_CORES=1, P=Q=R=2, A=[1 2;3 4], B=[5 6;7 8], gnt=1 -> writes C=[19 22;43 50] at C_BASE..+3. end_process pulse 4·(4·2+3)+2 cycles after start.
- NUM_CORES=4, core_id=1, P=6, Q=1, R=1 -> writes only rows 1 and 5, then end_process.
- dram_gnt random 30% -> identical C contents. dram_addr, dram_wdata and dram_wr_en are stable on every stalled request cycle.
- dim_q=0, and separately core_id=3 with P=2 -> no dram_req. end_process 2 cycles after start.
- DATA_W=8, A=B=all 255, Q=2 -> written value 0x02 truncated. With SATURATE_EN: 0xFF and ovf=1.
- rst pulled low during RD_B with gnt=0 -> dram_req=0 and busy=0 immediately. After release, a new start completes correctly.

Source files
------------

// File: rtl/mm_dot_core_pkg.sv
// Shared types and helpers for the row-sequenced matrix-multiply core.
// Holds the FSM state encoding, accumulator sizing and default DRAM base addresses.
package mm_core_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ELEM_INIT = 4'd1,
    ST_RD_A      = 4'd2,
    ST_WAIT_A    = 4'd3,
    ST_RD_B      = 4'd4,
    ST_WAIT_B    = 4'd5,
    ST_WR_C      = 4'd6,
    ST_NEXT      = 4'd7,
    ST_FIN       = 4'd8
  } state_e;

  localparam int A_BASE_DEF = 0;
  localparam int B_BASE_DEF = 0;
  localparam int C_BASE_DEF = 0;

  // Product of two DATA_W operands summed up to 2^DIM_W-1 times cannot overflow this.
  function automatic int acc_width(input int data_w, input int dim_w);
    return 2 * data_w + dim_w;
  endfunction

  function automatic int id_width(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

endpackage

// File: rtl/mm_dot_core_if.sv
// Shared, arbitrated DRAM port: one request/grant handshake per access,
// read data returned the cycle after a granted read.
interface mm_dot_core_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              wr_en;
  logic              gnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr_en, addr, wdata, input gnt, rdata);
  modport slave  (input req, wr_en, addr, wdata, output gnt, rdata);
endinterface

// File: rtl/mm_dot_core_mac.sv
// mm_mac: registered unsigned multiply-accumulate with clear/enable.
// SATURATE_EN selects a clamped stored value plus a clamp flag; otherwise truncation.
module mm_mac
  import mm_core_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
`ifdef SATURATE_EN
  ,
  output logic              clamp
`endif
);

  localparam int ACC_W = acc_width(DATA_W, DIM_W);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod;

  assign prod = ACC_W'(a) * ACC_W'(b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod;
  end

`ifdef SATURATE_EN
  assign clamp  = |acc[ACC_W-1:DATA_W];
  assign result = clamp ? '1 : acc[DATA_W-1:0];
`else
  assign result = acc[DATA_W-1:0];
`endif

endmodule

// File: rtl/mm_dot_core.sv
// mm_dot_core: hard-sequenced dot-product core computing rows core_id, core_id+NUM_CORES, ...
// of C = A*B over a shared DRAM port. Define SATURATE_EN for clamped stores and a sticky ovf flag.
module mm_dot_core
  import mm_core_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DIM_W     = 8,
  parameter int NUM_CORES = 4,
  parameter int A_BASE    = A_BASE_DEF,
  parameter int B_BASE    = B_BASE_DEF,
  parameter int C_BASE    = C_BASE_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [id_width(NUM_CORES)-1:0]  core_id,
  input  logic [DIM_W-1:0]                dim_p,
  input  logic [DIM_W-1:0]                dim_q,
  input  logic [DIM_W-1:0]                dim_r,
  mm_dot_core_if.master                   dram,
  output logic                            busy,
  output logic                            end_process
`ifdef SATURATE_EN
  ,
  output logic                            ovf
`endif
);

  localparam logic [3:0] IDLE      = ST_IDLE;
  localparam logic [3:0] ELEM_INIT = ST_ELEM_INIT;
  localparam logic [3:0] RD_A      = ST_RD_A;
  localparam logic [3:0] WAIT_A    = ST_WAIT_A;
  localparam logic [3:0] RD_B      = ST_RD_B;
  localparam logic [3:0] WAIT_B    = ST_WAIT_B;
  localparam logic [3:0] WR_C      = ST_WR_C;
  localparam logic [3:0] NEXT      = ST_NEXT;
  localparam logic [3:0] FIN       = ST_FIN;

  localparam int IDX_W  = DIM_W + 1;
  localparam int PROD_W = 2 * DIM_W + 1;

  logic [3:0]        state;
  logic [DIM_W-1:0]  p_reg, q_reg, r_reg;
  logic [IDX_W-1:0]  i;
  logic [DIM_W-1:0]  j, k;
  logic [ADDR_W-1:0] a_ptr, b_ptr, c_ptr;
  logic [DATA_W-1:0] a_reg, c_val;

  logic [PROD_W-1:0] i_ext, iq, ir;
  logic [IDX_W-1:0]  i_step;
  logic [DIM_W-1:0]  j_inc, k_inc;
  logic              degenerate;

  assign i_ext      = PROD_W'(i);
  assign iq         = i_ext * PROD_W'(q_reg);
  assign ir         = i_ext * PROD_W'(r_reg);
  assign i_step     = i + IDX_W'(NUM_CORES);
  assign j_inc      = j + DIM_W'(1);
  assign k_inc      = k + DIM_W'(1);
  assign degenerate = (dim_p == '0) || (dim_q == '0) || (dim_r == '0) ||
                      (IDX_W'(core_id) >= IDX_W'(dim_p));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      end_process <= 1'b0;
      p_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      a_ptr       <= '0;
      b_ptr       <= '0;
      c_ptr       <= '0;
      a_reg       <= '0;
    end else begin
      end_process <= 1'b0;
      case (state)
        IDLE: if (start) begin
          p_reg <= dim_p;
          q_reg <= dim_q;
          r_reg <= dim_r;
          i     <= IDX_W'(core_id);
          j     <= '0;
          busy  <= 1'b1;
          state <= degenerate ? FIN : ELEM_INIT;
        end
        ELEM_INIT: begin
          k     <= '0;
          a_ptr <= ADDR_W'(A_BASE) + ADDR_W'(iq);
          b_ptr <= ADDR_W'(B_BASE) + ADDR_W'(j);
          c_ptr <= ADDR_W'(C_BASE) + ADDR_W'(ir) + ADDR_W'(j);
          state <= RD_A;
        end
        RD_A: if (dram.gnt) state <= WAIT_A;
        WAIT_A: begin
          a_reg <= dram.rdata;
          state <= RD_B;
        end
        RD_B: if (dram.gnt) state <= WAIT_B;
        WAIT_B: begin
          a_ptr <= a_ptr + ADDR_W'(1);
          b_ptr <= b_ptr + ADDR_W'(r_reg);
          k     <= k_inc;
          state <= (k_inc == q_reg) ? WR_C : RD_A;
        end
        WR_C: if (dram.gnt) state <= NEXT;
        NEXT: begin
          if (j_inc == r_reg) begin
            j     <= '0;
            i     <= i_step;
            state <= (i_step >= IDX_W'(p_reg)) ? FIN : ELEM_INIT;
          end else begin
            j     <= j_inc;
            state <= ELEM_INIT;
          end
        end
        FIN: begin
          end_process <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request outputs decode purely from state, so they hold steady while a grant is pending.
  // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
  always_comb begin
    dram.req   = 1'b0;
    dram.wr_en = 1'b0;
    dram.addr  = '0;
    dram.wdata = '0;
    case (state)
      RD_A: begin
        dram.req  = 1'b1;
        dram.addr = a_ptr;
      end
      RD_B: begin
        dram.req  = 1'b1;
        dram.addr = b_ptr;
      end
      WR_C: begin
        dram.req   = 1'b1;
        dram.wr_en = 1'b1;
        dram.addr  = c_ptr;
        dram.wdata = c_val;
      end
      default: ;
    endcase
  end

`ifdef SATURATE_EN
  logic clamp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                ovf <= 1'b0;
    else if (state == IDLE && start)         ovf <= 1'b0;
    else if (state == WR_C && dram.gnt && clamp) ovf <= 1'b1;
  end
`endif

  mm_mac #(
    .DATA_W (DATA_W),
    .DIM_W  (DIM_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ELEM_INIT),
    .en     (state == WAIT_B),
    .a      (a_reg),
    .b      (dram.rdata),
    .result (c_val)
`ifdef SATURATE_EN
    ,
    .clamp  (clamp)
`endif
  );

endmodule

// File: tb/tb_mm_dot_core.sv
// Scoreboard bench for mm_dot_core: two instances (NUM_CORES=1/DATA_W=16 and NUM_CORES=4/DATA_W=8)
// with DRAM models; expected writes are queued at stimulus time and popped by per-port monitors.
module tb_mm_dot_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mm_dot_core_if #(.ADDR_W(16), .DATA_W(16)) if_a ();
  mm_dot_core_if #(.ADDR_W(16), .DATA_W(8))  if_b ();

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] p_a = '0, q_a = '0, r_a = '0;
  logic [7:0] p_b = '0, q_b = '0, r_b = '0;
  logic [0:0] cid_a = '0;
  logic [1:0] cid_b = '0;
  logic       busy_a, end_a, busy_b, end_b;
`ifdef SATURATE_EN
  logic       ovf_a, ovf_b;
`endif

  mm_dot_core #(
    .DATA_W(16), .ADDR_W(16), .DIM_W(8), .NUM_CORES(1),
    .A_BASE(0), .B_BASE(16), .C_BASE(32)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .core_id(cid_a),
    .dim_p(p_a), .dim_q(q_a), .dim_r(r_a), .dram(if_a),
    .busy(busy_a), .end_process(end_a)
`ifdef SATURATE_EN
    , .ovf(ovf_a)
`endif
  );

  mm_dot_core #(
    .DATA_W(8), .ADDR_W(16), .DIM_W(8), .NUM_CORES(4),
    .A_BASE(0), .B_BASE(16), .C_BASE(32)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .core_id(cid_b),
    .dim_p(p_b), .dim_q(q_b), .dim_r(r_b), .dram(if_b),
    .busy(busy_b), .end_process(end_b)
`ifdef SATURATE_EN
    , .ovf(ovf_b)
`endif
  );

  // DRAM models: A/B images loaded by the stimulus, C writes captured separately.
  logic [15:0] mem_a   [0:255];
  logic [15:0] c_mem_a [0:255];
  logic [7:0]  mem_b   [0:255];
  logic [7:0]  c_mem_b [0:255];

  always @(posedge clk) begin
    if (if_a.req && if_a.gnt) begin
      if (if_a.wr_en) c_mem_a[if_a.addr[7:0]] <= if_a.wdata;
      else            if_a.rdata <= mem_a[if_a.addr[7:0]];
    end
    if (if_b.req && if_b.gnt) begin
      if (if_b.wr_en) c_mem_b[if_b.addr[7:0]] <= if_b.wdata;
      else            if_b.rdata <= mem_b[if_b.addr[7:0]];
    end
  end

  // Grant drivers: fixed level or 30% random, updated just after each rising edge.
  bit   rnd_a = 1'b0;
  logic gnt_fix_a = 1'b1, gnt_fix_b = 1'b1;
  initial forever begin
    @(posedge clk);
    #1;
    if_a.gnt = rnd_a ? ($urandom_range(0, 99) < 30) : gnt_fix_a;
    if_b.gnt = gnt_fix_b;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int addr; int data; } wr_t;
  wr_t q_exp_a[$];
  wr_t q_exp_b[$];
  wr_t ea, eb;

  function automatic void push_a(input int addr, input int data);
    wr_t e;
    e.addr = addr; e.data = data;
    q_exp_a.push_back(e);
  endfunction

  function automatic void push_b(input int addr, input int data);
    wr_t e;
    e.addr = addr; e.data = data;
    q_exp_b.push_back(e);
  endfunction

  // Monitors: pop on every granted write; verify request hold on stalled cycles.
  logic        pa_stall = 1'b0, pa_wr;
  logic [15:0] pa_addr, pa_wdata;
  always @(negedge clk) begin
    if (!rst) pa_stall = 1'b0;
    else begin
      if (pa_stall) begin
        check("a_hold_req",   if_a.req,   1);
        check("a_hold_addr",  if_a.addr,  pa_addr);
        check("a_hold_wr_en", if_a.wr_en, pa_wr);
        check("a_hold_wdata", if_a.wdata, pa_wdata);
      end
      if (if_a.req && if_a.gnt && if_a.wr_en) begin
        if (q_exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_write: unexpected write addr=%0d data=%0d", if_a.addr, if_a.wdata);
        end else begin
          ea = q_exp_a.pop_front();
          check("a_wr_addr", if_a.addr,  ea.addr);
          check("a_wr_data", if_a.wdata, ea.data);
        end
      end
      pa_stall = if_a.req && !if_a.gnt;
      pa_addr  = if_a.addr;
      pa_wr    = if_a.wr_en;
      pa_wdata = if_a.wdata;
    end
  end

  logic        pb_stall = 1'b0, pb_wr;
  logic [15:0] pb_addr;
  logic [7:0]  pb_wdata;
  always @(negedge clk) begin
    if (!rst) pb_stall = 1'b0;
    else begin
      if (pb_stall) begin
        check("b_hold_req",   if_b.req,   1);
        check("b_hold_addr",  if_b.addr,  pb_addr);
        check("b_hold_wr_en", if_b.wr_en, pb_wr);
        check("b_hold_wdata", if_b.wdata, pb_wdata);
      end
      if (if_b.req && if_b.gnt && if_b.wr_en) begin
        if (q_exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_write: unexpected write addr=%0d data=%0d", if_b.addr, if_b.wdata);
        end else begin
          eb = q_exp_b.pop_front();
          check("b_wr_addr", if_b.addr,  eb.addr);
          check("b_wr_data", if_b.wdata, eb.data);
        end
      end
      pb_stall = if_b.req && !if_b.gnt;
      pb_addr  = if_b.addr;
      pb_wr    = if_b.wr_en;
      pb_wdata = if_b.wdata;
    end
  end

  function automatic logic req_of(input int w);
    return (w == 0) ? if_a.req : if_b.req;
  endfunction

  function automatic logic end_of(input int w);
    return (w == 0) ? end_a : end_b;
  endfunction

  // Issues one start pulse and counts rising edges (the start-sampling edge is 1)
  // until end_process is seen; also records when dram_req first appears.
  task automatic run_job(input int w, input int p, input int q, input int r, input int cid,
                         input int budget, output int n_end, output int n_req);
    int n;
    @(negedge clk);
    if (w == 0) begin
      p_a = 8'(p); q_a = 8'(q); r_a = 8'(r); cid_a = 1'(cid); start_a = 1'b1;
    end else begin
      p_b = 8'(p); q_b = 8'(q); r_b = 8'(r); cid_b = 2'(cid); start_b = 1'b1;
    end
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    n_req = 0;
    n_end = -1;
    while (n < budget) begin
      if (n_req == 0 && req_of(w)) n_req = n;
      if (end_of(w)) begin
        n_end = n;
        break;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (n_end < 0) begin
      total++; bad++;
      $display("FAIL job_timeout: core %0d gave no end_process within %0d cycles", w, budget);
    end
  endtask

  initial begin
    int n_end, n_req, hit;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy_a",  busy_a,     0);
    check("rst_end_a",   end_a,      0);
    check("rst_req_a",   if_a.req,   0);
    check("rst_wr_a",    if_a.wr_en, 0);
    check("rst_addr_a",  if_a.addr,  0);
    check("rst_wdata_a", if_a.wdata, 0);
    check("rst_req_b",   if_b.req,   0);
    check("rst_busy_b",  busy_b,     0);
`ifdef SATURATE_EN
    check("rst_ovf_b",   ovf_b,      0);
`endif
    @(posedge clk);
    #2 rst = 1'b1;

    // 2x2 by 2x2, grant always: C=[19 22;43 50]
    mem_a[0] = 16'd1; mem_a[1] = 16'd2; mem_a[2] = 16'd3; mem_a[3] = 16'd4;
    mem_a[16] = 16'd5; mem_a[17] = 16'd6; mem_a[18] = 16'd7; mem_a[19] = 16'd8;
    push_a(32, 19); push_a(33, 22); push_a(34, 43); push_a(35, 50);
    run_job(0, 2, 2, 2, 0, 200, n_end, n_req);
    check("t1_end_cycle",   n_end, 46);
    check("t1_first_req",   n_req, 2);
    check("t1_busy_low",    busy_a, 0);
    check("t1_writes_done", q_exp_a.size(), 0);

    // Same job under random 30% grant
    rnd_a = 1'b1;
    push_a(32, 19); push_a(33, 22); push_a(34, 43); push_a(35, 50);
    run_job(0, 2, 2, 2, 0, 2000, n_end, n_req);
    rnd_a = 1'b0;
    check("t3_c00", c_mem_a[32], 19);
    check("t3_c01", c_mem_a[33], 22);
    check("t3_c10", c_mem_a[34], 43);
    check("t3_c11", c_mem_a[35], 50);
    check("t3_writes_done", q_exp_a.size(), 0);

    // Q=0: no DRAM access, end_process 2 cycles after start
    run_job(0, 2, 0, 2, 0, 50, n_end, n_req);
    check("t4a_end_cycle", n_end, 2);
    check("t4a_no_req",    n_req, 0);

    // Reset while stalled in RD_B
    @(negedge clk);
    gnt_fix_a = 1'b0;
    repeat (2) @(negedge clk);
    p_a = 8'd2; q_a = 8'd2; r_a = 8'd2; cid_a = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    hit = 0;
    for (int t = 0; t < 20; t++) begin
      if (if_a.req && if_a.addr == 16'd0) begin hit = 1; break; end
      @(negedge clk);
    end
    check("t6_rd_a_seen", hit, 1);
    gnt_fix_a = 1'b1;
    @(negedge clk);
    gnt_fix_a = 1'b0;
    hit = 0;
    for (int t = 0; t < 20; t++) begin
      if (if_a.req && if_a.addr == 16'd16) begin hit = 1; break; end
      @(negedge clk);
    end
    check("t6_rd_b_seen", hit, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_req_abort",  if_a.req, 0);
    check("t6_busy_abort", busy_a,   0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    gnt_fix_a = 1'b1;
    push_a(32, 19); push_a(33, 22); push_a(34, 43); push_a(35, 50);
    run_job(0, 2, 2, 2, 0, 200, n_end, n_req);
    check("t6_restart_end", n_end, 46);
    check("t6_writes_done", q_exp_a.size(), 0);

    // NUM_CORES=4, core 1, P=6 Q=1 R=1: only rows 1 and 5
    for (int x = 0; x < 6; x++) mem_b[x] = 8'(x + 1);
    mem_b[16] = 8'd3;
    push_b(33, 6); push_b(37, 18);
    run_job(1, 6, 1, 1, 1, 200, n_end, n_req);
    check("t2_end_cycle",   n_end, 16);
    check("t2_first_req",   n_req, 2);
    check("t2_writes_done", q_exp_b.size(), 0);
`ifdef SATURATE_EN
    check("t2_no_ovf", ovf_b, 0);
`endif

    // core_id=3 with P=2: nothing to do
    run_job(1, 2, 2, 2, 3, 50, n_end, n_req);
    check("t4b_end_cycle", n_end, 2);
    check("t4b_no_req",    n_req, 0);

    // 8-bit elements, 255*255*2 = 0x1FC02
    mem_b[0] = 8'hFF; mem_b[1] = 8'hFF; mem_b[16] = 8'hFF; mem_b[17] = 8'hFF;
`ifdef SATURATE_EN
    push_b(32, 255);
`else
    push_b(32, 2);
`endif
    run_job(1, 1, 2, 1, 0, 200, n_end, n_req);
    check("t5_end_cycle",   n_end, 13);
    check("t5_writes_done", q_exp_b.size(), 0);
`ifdef SATURATE_EN
    check("t5_ovf", ovf_b, 1);
`endif

    repeat (3) @(posedge clk);
    check("final_queue_a", q_exp_a.size(), 0);
    check("final_queue_b", q_exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
